// File: rtl/lane_draw_engine.sv
// Pixel-command engine: rasterises CLEAR/FILL/SPRITE/FLOORS commands into a one-pixel-per-clock
// x/y/color/plot stream. Define LANE_DRAW_ENGINE_CLIP_EN to suppress plots that fall off-screen.
module lane_draw_engine #(
  parameter int SCR_W      = 160,
  parameter int SCR_H      = 120,
  parameter int XW         = 8,
  parameter int YW         = 7,
  parameter int CW         = 3,
  parameter int N_LANES    = 3,
  parameter int FLOOR_Y0   = 35,
  parameter int LANE_PITCH = 40,
  parameter int FLOOR_H    = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [XW-1:0] cmd_x,
  input  logic [YW-1:0] cmd_y,
  input  logic [XW-1:0] cmd_w,
  input  logic [YW-1:0] cmd_h,
  input  logic [CW-1:0] cmd_color,
  input  logic [63:0]   cmd_mask,
  input  logic          abort,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] color,
  output logic          plot,
  output logic          done
);

  localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  localparam logic [1:0] OP_CLEAR  = 2'b00;
  localparam logic [1:0] OP_FILL   = 2'b01;
  localparam logic [1:0] OP_SPRITE = 2'b10;
  localparam logic [1:0] OP_FLOORS = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  typedef struct packed {
    logic [1:0]    op;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [XW-1:0] w;
    logic [YW-1:0] h;
    logic [CW-1:0] color;
    logic [63:0]   mask;
  } cmd_t;

  state_t        state_q, state_d;
  cmd_t          cmd_q, cmd_d, cmd_in, src;
  logic [XW:0]   cx_q, cx_d;
  logic [YW:0]   cy_q, cy_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [YW:0]   ybase_q, ybase_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] color_q, color_d;
  logic          plot_q, plot_d;
  logic          done_q, done_d;

  logic [XW:0]   wlim, nx, pcx, xs, xfull;
  logic [YW:0]   hlim, ny, pcy, ys, yfull, nb, pyb;
  logic [LW-1:0] nl;
  logic          last_col, last_row, last_lane, last_pos;
  logic          hs, degen, pix_plot;
  logic [5:0]    midx;

  assign cmd_ready = (state_q == S_IDLE) && reset_n;
  assign hs        = cmd_valid && cmd_ready;

  always_comb begin
    cmd_in.op    = cmd_op;
    cmd_in.x     = cmd_x;
    cmd_in.y     = cmd_y;
    cmd_in.w     = cmd_w;
    cmd_in.h     = cmd_h;
    cmd_in.color = cmd_color;
    cmd_in.mask  = cmd_mask;
    // While idle the first pixel is built straight from the offered command
    src = (state_q == S_IDLE) ? cmd_in : cmd_q;

    case (src.op)
      OP_CLEAR:  begin wlim = (XW+1)'(SCR_W); hlim = (YW+1)'(SCR_H);   end
      OP_FILL:   begin wlim = {1'b0, src.w};  hlim = {1'b0, src.h};    end
      OP_SPRITE: begin wlim = (XW+1)'(8);     hlim = (YW+1)'(8);       end
      default:   begin wlim = (XW+1)'(SCR_W); hlim = (YW+1)'(FLOOR_H); end
    endcase

    last_col  = (cx_q == wlim - 1'b1);
    last_row  = (cy_q == hlim - 1'b1);
    last_lane = (src.op != OP_FLOORS) || (lane_q == LW'(N_LANES - 1));
    last_pos  = last_col && last_row && last_lane;

    nx = last_col ? '0 : cx_q + 1'b1;
    ny = cy_q;
    nl = lane_q;
    nb = ybase_q;
    if (last_col) begin
      if (last_row) begin
        ny = '0;
        nl = lane_q + 1'b1;
        nb = ybase_q + (YW+1)'(LANE_PITCH);
      end else begin
        ny = cy_q + 1'b1;
      end
    end

    if (state_q == S_IDLE) begin
      pcx = '0;
      pcy = '0;
      pyb = (YW+1)'(FLOOR_Y0);
    end else begin
      pcx = nx;
      pcy = ny;
      pyb = nb;
    end

    xs    = (src.op == OP_FILL || src.op == OP_SPRITE) ? {1'b0, src.x} : '0;
    ys    = (src.op == OP_FILL || src.op == OP_SPRITE) ? {1'b0, src.y} :
            (src.op == OP_FLOORS) ? pyb : '0;
    xfull = xs + pcx;
    yfull = ys + pcy;
    midx  = {pcy[2:0], pcx[2:0]};
    pix_plot = (src.op == OP_SPRITE) ? src.mask[midx] : 1'b1;
`ifdef LANE_DRAW_ENGINE_CLIP_EN
    if (xfull >= (XW+1)'(SCR_W) || yfull >= (YW+1)'(SCR_H)) pix_plot = 1'b0;
`endif

    degen = (cmd_op == OP_FILL) && ((cmd_w == '0) || (cmd_h == '0));
  end

`ifndef LANE_DRAW_ENGINE_CLIP_EN
  logic unused_ovf;
  assign unused_ovf = xfull[XW] ^ yfull[YW];
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    lane_d  = lane_q;
    ybase_d = ybase_q;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
    plot_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hs) begin
          cmd_d   = cmd_in;
          cx_d    = '0;
          cy_d    = '0;
          lane_d  = '0;
          ybase_d = (YW+1)'(FLOOR_Y0);
          if (degen) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            x_d     = xfull[XW-1:0];
            y_d     = yfull[YW-1:0];
            color_d = src.color;
            plot_d  = pix_plot;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (last_pos) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          cx_d    = nx;
          cy_d    = ny;
          lane_d  = nl;
          ybase_d = nb;
          x_d     = xfull[XW-1:0];
          y_d     = yfull[YW-1:0];
          color_d = src.color;
          plot_d  = pix_plot;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      lane_q  <= '0;
      ybase_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      plot_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      lane_q  <= lane_d;
      ybase_q <= ybase_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
      plot_q  <= plot_d;
      done_q  <= done_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign color = color_q;
  assign plot  = plot_q;
  assign done  = done_q;

endmodule
